// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the 8-bit bus CPU control sequencer: opcodes, micro-steps,
// control-word bit layout and the per-opcode last step used by CTRL_EARLY_FETCH_EN.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Control word is held in output polarity: *_n bits idle high, su/ce/hlt idle low.
    localparam int CW_HLT  = 0;
    localparam int CW_MI_N = 1;
    localparam int CW_RI_N = 2;
    localparam int CW_RO_N = 3;
    localparam int CW_II_N = 4;
    localparam int CW_IO_N = 5;
    localparam int CW_AI_N = 6;
    localparam int CW_AO_N = 7;
    localparam int CW_BI_N = 8;
    localparam int CW_EO_N = 9;
    localparam int CW_SU   = 10;
    localparam int CW_FI_N = 11;
    localparam int CW_OI_N = 12;
    localparam int CW_CO_N = 13;
    localparam int CW_J_N  = 14;
    localparam int CW_CE   = 15;
    localparam int CW_W    = 16;

    localparam logic [CW_W-1:0] CW_IDLE =
        ~((CW_W'(1) << CW_HLT) | (CW_W'(1) << CW_SU) | (CW_W'(1) << CW_CE));

    function automatic logic [2:0] last_step(input logic [3:0] op);
        case (op)
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = T2;
            OP_LDA, OP_STA:                               last_step = T3;
            OP_ADD, OP_SUB:                               last_step = T4;
            default:                                      last_step = T1;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_step_counter.sv
// Micro-step counter: wraps at NUM_STEPS-1, freezes under hold, and restarts
// at T0 on early_rst. hold wins over early_rst; clr wins over everything.
module ctrl_step_counter #(
    parameter  int NUM_STEPS = 5,
    localparam int STEP_W    = $clog2(NUM_STEPS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              hold,
    input  logic              early_rst,
    output logic [STEP_W-1:0] step
);

    logic [STEP_W-1:0] r_step;

    always_ff @(posedge clk) begin
        if (clr)
            r_step <= '0;
        else if (hold)
            r_step <= r_step;
        else if (early_rst || r_step == STEP_W'(NUM_STEPS - 1))
            r_step <= '0;
        else
            r_step <= r_step + STEP_W'(1);
    end

    assign step = r_step;

endmodule

// File: rtl/ctrl_sequencer.sv
// Microcoded control sequencer: decodes (step, halted, opcode, flags) into the
// bus control word. Define CTRL_EARLY_FETCH_EN to end each instruction at its last used step.
module ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter  int NUM_STEPS = 5,
    parameter  int OPCODE_W  = 4,
    localparam int STEP_W    = $clog2(NUM_STEPS)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_f,
    input  logic                zero_f,
    output logic [STEP_W-1:0]   step,
    output logic                hlt,
    output logic                mi_n,
    output logic                ri_n,
    output logic                ro_n,
    output logic                ii_n,
    output logic                io_n,
    output logic                ai_n,
    output logic                ao_n,
    output logic                bi_n,
    output logic                eo_n,
    output logic                su,
    output logic                fi_n,
    output logic                oi_n,
    output logic                co_n,
    output logic                j_n,
    output logic                ce
);

    logic              r_halted;
    logic              w_halt_now;
    logic              w_early_rst;
    logic [STEP_W-1:0] w_step;
    logic [CW_W-1:0]   w_cw;

    assign w_halt_now = !r_halted && (w_step == T2) && (opcode == OP_HLT);

`ifdef CTRL_EARLY_FETCH_EN
    assign w_early_rst = (w_step == last_step(opcode));
`else
    assign w_early_rst = 1'b0;
`endif

    ctrl_step_counter #(.NUM_STEPS(NUM_STEPS)) u_step (
        .clk       (clk),
        .clr       (clr),
        .hold      (r_halted | w_halt_now),
        .early_rst (w_early_rst),
        .step      (w_step)
    );

    always_ff @(posedge clk) begin
        if (clr)
            r_halted <= 1'b0;
        else if (w_halt_now)
            r_halted <= 1'b1;
    end

    always_comb begin
        w_cw = CW_IDLE;
        if (r_halted) begin
            w_cw[CW_HLT] = 1'b1;
        end else begin
            case (w_step)
                T0: begin
                    w_cw[CW_CO_N] = 1'b0;
                    w_cw[CW_MI_N] = 1'b0;
                end
                T1: begin
                    w_cw[CW_RO_N] = 1'b0;
                    w_cw[CW_II_N] = 1'b0;
                    w_cw[CW_CE]   = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            w_cw[CW_IO_N] = 1'b0;
                            w_cw[CW_MI_N] = 1'b0;
                        end
                        OP_LDI: begin
                            w_cw[CW_IO_N] = 1'b0;
                            w_cw[CW_AI_N] = 1'b0;
                        end
                        OP_JMP: begin
                            w_cw[CW_IO_N] = 1'b0;
                            w_cw[CW_J_N]  = 1'b0;
                        end
                        // Flags are taken as-is this cycle; no filtering of late changes.
                        OP_JC: begin
                            w_cw[CW_IO_N] = !carry_f;
                            w_cw[CW_J_N]  = !carry_f;
                        end
                        OP_JZ: begin
                            w_cw[CW_IO_N] = !zero_f;
                            w_cw[CW_J_N]  = !zero_f;
                        end
                        OP_OUT: begin
                            w_cw[CW_AO_N] = 1'b0;
                            w_cw[CW_OI_N] = 1'b0;
                        end
                        OP_HLT: w_cw[CW_HLT] = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            w_cw[CW_RO_N] = 1'b0;
                            w_cw[CW_AI_N] = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            w_cw[CW_RO_N] = 1'b0;
                            w_cw[CW_BI_N] = 1'b0;
                        end
                        OP_STA: begin
                            w_cw[CW_AO_N] = 1'b0;
                            w_cw[CW_RI_N] = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        w_cw[CW_EO_N] = 1'b0;
                        w_cw[CW_AI_N] = 1'b0;
                        w_cw[CW_FI_N] = 1'b0;
                        w_cw[CW_SU]   = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign step = w_step;
    assign hlt  = w_cw[CW_HLT];
    assign mi_n = w_cw[CW_MI_N];
    assign ri_n = w_cw[CW_RI_N];
    assign ro_n = w_cw[CW_RO_N];
    assign ii_n = w_cw[CW_II_N];
    assign io_n = w_cw[CW_IO_N];
    assign ai_n = w_cw[CW_AI_N];
    assign ao_n = w_cw[CW_AO_N];
    assign bi_n = w_cw[CW_BI_N];
    assign eo_n = w_cw[CW_EO_N];
    assign su   = w_cw[CW_SU];
    assign fi_n = w_cw[CW_FI_N];
    assign oi_n = w_cw[CW_OI_N];
    assign co_n = w_cw[CW_CO_N];
    assign j_n  = w_cw[CW_J_N];
    assign ce   = w_cw[CW_CE];

    // Only one source may drive the shared bus in any cycle.
    a_bus_single_driver: assert property (@(posedge clk) disable iff (clr)
        $onehot0({~ro_n, ~io_n, ~ao_n, ~eo_n, ~co_n}));

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: stimulus pushes hand-computed expected
// (step, asserted-controls) per cycle; a negedge monitor pops and compares.
module tb_ctrl_sequencer;

    localparam logic [15:0] M_MI  = 16'h0001;
    localparam logic [15:0] M_RI  = 16'h0002;
    localparam logic [15:0] M_RO  = 16'h0004;
    localparam logic [15:0] M_II  = 16'h0008;
    localparam logic [15:0] M_IO  = 16'h0010;
    localparam logic [15:0] M_AI  = 16'h0020;
    localparam logic [15:0] M_AO  = 16'h0040;
    localparam logic [15:0] M_BI  = 16'h0080;
    localparam logic [15:0] M_EO  = 16'h0100;
    localparam logic [15:0] M_SU  = 16'h0200;
    localparam logic [15:0] M_FI  = 16'h0400;
    localparam logic [15:0] M_OI  = 16'h0800;
    localparam logic [15:0] M_CO  = 16'h1000;
    localparam logic [15:0] M_J   = 16'h2000;
    localparam logic [15:0] M_CE  = 16'h4000;
    localparam logic [15:0] M_HLT = 16'h8000;
    localparam logic [15:0] F0    = M_CO | M_MI;
    localparam logic [15:0] F1    = M_RO | M_II | M_CE;

    typedef struct {
        logic [2:0]  stp;
        logic [15:0] m;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] opcode;
    logic       carry_f, zero_f;
    logic [2:0] step;
    logic hlt, mi_n, ri_n, ro_n, ii_n, io_n, ai_n, ao_n, bi_n, eo_n, su, fi_n, oi_n, co_n, j_n, ce;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_bus = 1'b0;

    always #5 clk = ~clk;

    ctrl_sequencer #(.NUM_STEPS(5), .OPCODE_W(4)) dut (
        .clk(clk), .clr(clr), .opcode(opcode), .carry_f(carry_f), .zero_f(zero_f),
        .step(step), .hlt(hlt), .mi_n(mi_n), .ri_n(ri_n), .ro_n(ro_n), .ii_n(ii_n),
        .io_n(io_n), .ai_n(ai_n), .ao_n(ao_n), .bi_n(bi_n), .eo_n(eo_n), .su(su),
        .fi_n(fi_n), .oi_n(oi_n), .co_n(co_n), .j_n(j_n), .ce(ce)
    );

    wire [15:0] act = {hlt, ce, ~j_n, ~co_n, ~oi_n, ~fi_n, su, ~eo_n,
                       ~bi_n, ~ao_n, ~ai_n, ~io_n, ~ii_n, ~ro_n, ~ri_n, ~mi_n};
    wire [4:0]  bus = {~ro_n, ~io_n, ~ao_n, ~eo_n, ~co_n};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (step !== e.stp || act !== e.m) begin
                n_bad++;
                $display("FAIL %s: got step=%0d ctl=%h, want step=%0d ctl=%h",
                         e.name, step, act, e.stp, e.m);
            end
        end
        if (chk_bus) begin
            n_cmp++;
            if (!$onehot0(bus) || $isunknown(bus)) begin
                n_bad++;
                $display("FAIL bus_single_driver: got drivers=%b, want at most one", bus);
            end
        end
    end

    // Drive one cycle of inputs and queue what the outputs must show during it.
    task automatic cyc(input logic [3:0] op, input logic c, input logic z, input logic r,
                       input logic [2:0] s, input logic [15:0] m, input string nm);
        exp_t e;
        opcode = op; carry_f = c; zero_f = z; clr = r;
        e.stp = s; e.m = m; e.name = $sformatf("%s_T%0d", nm, s);
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic instr(input logic [3:0] op, input logic c, input logic z,
                         input logic [15:0] m2, input logic [15:0] m3, input logic [15:0] m4,
                         input int last, input string nm);
        int n;
        logic [15:0] m;
        n = 4;
`ifdef CTRL_EARLY_FETCH_EN
        n = last;
`endif
        for (int s = 0; s <= n; s++) begin
            m = (s == 0) ? F0 : (s == 1) ? F1 : (s == 2) ? m2 : (s == 3) ? m3 : m4;
            cyc(op, c, z, 1'b0, 3'(s), m, nm);
        end
    endtask

    initial begin
        clr = 1'b1; opcode = 4'h2; carry_f = 1'b0; zero_f = 1'b0;
        @(posedge clk); #1;
        cyc(4'h2, 1'b0, 1'b0, 1'b1, 3'd0, F0, "reset_hold");
        chk_bus = 1'b1;

        instr(4'h2, 0, 0, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI, 4, "ADD");
        instr(4'h3, 0, 0, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI | M_SU, 4, "SUB");
        instr(4'h4, 0, 0, M_IO | M_MI, M_AO | M_RI, 16'h0, 3, "STA");
        instr(4'h5, 0, 0, M_IO | M_AI, 16'h0, 16'h0, 2, "LDI");
        instr(4'hE, 0, 0, M_AO | M_OI, 16'h0, 16'h0, 2, "OUT");
        instr(4'h1, 0, 0, M_IO | M_MI, M_RO | M_AI, 16'h0, 3, "LDA");
        instr(4'h6, 0, 0, M_IO | M_J, 16'h0, 16'h0, 2, "JMP");
        instr(4'h7, 1, 0, M_IO | M_J, 16'h0, 16'h0, 2, "JC_taken");
        instr(4'h7, 0, 1, 16'h0, 16'h0, 16'h0, 2, "JC_not");
        instr(4'h8, 0, 1, M_IO | M_J, 16'h0, 16'h0, 2, "JZ_taken");
        instr(4'h8, 1, 0, 16'h0, 16'h0, 16'h0, 2, "JZ_not");
        instr(4'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1, "NOP");
        instr(4'hB, 0, 0, 16'h0, 16'h0, 16'h0, 1, "UNDEF_B");

        // Back-to-back LDI, LDA, ADD: early fetch gives step run 0,1,2,0,1,2,3,0,1,2,3,4.
        instr(4'h5, 0, 0, M_IO | M_AI, 16'h0, 16'h0, 2, "B2B_LDI");
        instr(4'h1, 0, 0, M_IO | M_MI, M_RO | M_AI, 16'h0, 3, "B2B_LDA");
        instr(4'h2, 0, 0, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI, 4, "B2B_ADD");

        // clr mid-instruction at T3 aborts to T0.
        cyc(4'h2, 0, 0, 1'b0, 3'd0, F0, "ABORT");
        cyc(4'h2, 0, 0, 1'b0, 3'd1, F1, "ABORT");
        cyc(4'h2, 0, 0, 1'b0, 3'd2, M_IO | M_MI, "ABORT");
        cyc(4'h2, 0, 0, 1'b1, 3'd3, M_RO | M_BI, "ABORT_clr");
        cyc(4'h2, 0, 0, 1'b0, 3'd0, F0, "ABORT_after");
        cyc(4'h2, 0, 0, 1'b0, 3'd1, F1, "ABORT_after");
        cyc(4'h2, 0, 0, 1'b0, 3'd2, M_IO | M_MI, "ABORT_after");
        cyc(4'h2, 0, 0, 1'b0, 3'd3, M_RO | M_BI, "ABORT_after");
        cyc(4'h2, 0, 0, 1'b0, 3'd4, M_EO | M_AI | M_FI, "ABORT_after");

        // HLT: freeze at T2 with only hlt, whatever the opcode, until clr.
        cyc(4'hF, 0, 0, 1'b0, 3'd0, F0, "HLT");
        cyc(4'hF, 0, 0, 1'b0, 3'd1, F1, "HLT");
        cyc(4'hF, 0, 0, 1'b0, 3'd2, M_HLT, "HLT");
        for (int i = 0; i < 20; i++) begin
            cyc(4'(i), 1'(i), 1'(i >> 1), 1'b0, 3'd2, M_HLT, $sformatf("HALTED%0d", i));
        end
        cyc(4'h2, 0, 0, 1'b1, 3'd2, M_HLT, "HALT_clr");
        cyc(4'h2, 0, 0, 1'b0, 3'd0, F0, "HALT_exit");
        cyc(4'h2, 0, 0, 1'b0, 3'd1, F1, "HALT_exit");

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
